// File: rtl/clk_mon_if.sv
// Status and control bundle between the clock monitor and its host.
interface clk_mon_if #(
  parameter int unsigned CNT_W = 8
);
  logic             mon_en;
  logic             err_clr;
  logic             clk_a_in;
  logic             clk_b_in;
  logic             a_lock;
  logic             b_lock;
  logic             all_lock;
  logic             a_err;
  logic             b_err;
  logic [CNT_W-1:0] a_period;
  logic [CNT_W-1:0] b_period;
  logic             err_irq;

  modport master (
    output mon_en, err_clr, clk_a_in, clk_b_in,
    input  a_lock, b_lock, all_lock, a_err, b_err, a_period, b_period, err_irq
  );

  modport slave (
    input  mon_en, err_clr, clk_a_in, clk_b_in,
    output a_lock, b_lock, all_lock, a_err, b_err, a_period, b_period, err_irq
  );
endinterface

// File: rtl/clk_mon.sv
// Clock monitor: measures the period of two divided clocks in clk_50m cycles,
// tracks lock per channel and flags period/stuck faults with sticky error bits.
module clk_mon #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned A_PERIOD = 5,
  parameter int unsigned B_PERIOD = 26,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input logic      clk_50m,
  input logic      rst_n,
  clk_mon_if.slave bus
);

  // One spare bit so good+1 never wraps before it is clamped to LOCK_CNT.
  localparam int unsigned GoodW = $clog2(LOCK_CNT + 2);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StLocked} state_e;

  logic [1:0]            clk_in;
  logic [1:0]            lock;
  logic [1:0]            err_ev;
  logic [1:0][CNT_W-1:0] period;
  logic [1:0]            err_q, err_d;
  logic                  all_lock_q;
  logic                  irq_q, irq_d;

  assign clk_in = {bus.clk_b_in, bus.clk_a_in};

  for (genvar c = 0; c < 2; c++) begin : g_chan
    localparam int unsigned      Expected = (c == 0) ? A_PERIOD : B_PERIOD;
    localparam logic [CNT_W:0]   ExpW     = (CNT_W + 1)'(Expected);
    localparam logic [CNT_W:0]   TolW     = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   DiffOne  = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntTo    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [GoodW-1:0] GoodOne  = GoodW'(1);
    localparam logic [GoodW-1:0] GoodLock = GoodW'(LOCK_CNT);

    logic [2:0]       sync_q;
    logic             rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic [GoodW-1:0] good_q, good_d, good_inc;
    logic [CNT_W:0]   diff, adiff;
    logic             in_tol;
    logic             timeout;
    logic             ev;

    // s1/s2/s3 live in bits 0/1/2; the fixed latency cancels out of the period.
    assign rise     = sync_q[1] & ~sync_q[2];
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    assign good_inc = good_q + GoodOne;
    // Signed deviation in CNT_W+1 bits, then magnitude.
    assign diff     = {1'b0, cnt_q} - ExpW;
    assign adiff    = diff[CNT_W] ? (~diff + DiffOne) : diff;
    assign in_tol   = (adiff <= TolW);
    assign timeout  = (cnt_q == CntTo) & ~rise;

    // Next-state for the per-channel measurement FSM.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      good_d   = good_q;
      period_d = period_q;
      ev       = 1'b0;
      if (!bus.mon_en) begin
        state_d = StIdle;
        cnt_d   = '0;
        good_d  = '0;
      end else begin
        case (state_q)
          StIdle: begin
            cnt_d   = '0;
            good_d  = '0;
            state_d = StArm;
          end
          StArm: begin
            if (rise) begin
              cnt_d   = CntOne;
              state_d = StMeas;
            end else if (timeout) begin
              ev     = 1'b1;
              good_d = '0;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          StMeas, StLocked: begin
            if (rise) begin
              period_d = cnt_q;
              cnt_d    = CntOne;
              if (in_tol) begin
                if (good_inc >= GoodLock) begin
                  good_d  = GoodLock;
                  state_d = StLocked;
                end else begin
                  good_d  = good_inc;
                  state_d = StMeas;
                end
              end else begin
                good_d  = '0;
                ev      = 1'b1;
                state_d = StMeas;
              end
            end else if (timeout) begin
              // Stuck clock: rearm so the next edge restarts measurement.
              ev      = 1'b1;
              good_d  = '0;
              cnt_d   = '0;
              state_d = StArm;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Synchroniser, FSM and measurement registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
        sync_q   <= '0;
        state_q  <= StIdle;
        cnt_q    <= '0;
        good_q   <= '0;
        period_q <= '0;
      end else begin
        sync_q   <= {sync_q[1:0], clk_in[c]};
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        good_q   <= good_d;
        period_q <= period_d;
      end
    end

    assign lock[c]   = (state_q == StLocked);
    assign err_ev[c] = ev;
    assign period[c] = period_q;
  end

  // Sticky errors: a new event beats a coincident clear.
  always_comb begin
    err_d = err_q;
    if (bus.err_clr) begin
      err_d = '0;
    end
    err_d = err_d | err_ev;
    irq_d = (|err_d) & ~(|err_q);
  end

  // Shared status registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      irq_q      <= 1'b0;
      all_lock_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      irq_q      <= irq_d;
      all_lock_q <= &lock;
    end
  end

  assign bus.a_lock   = lock[0];
  assign bus.b_lock   = lock[1];
  assign bus.all_lock = all_lock_q;
  assign bus.a_err    = err_q[0];
  assign bus.b_err    = err_q[1];
  assign bus.a_period = period[0];
  assign bus.b_period = period[1];
  assign bus.err_irq  = irq_q;

endmodule
